link_parameter_loader: RTL and testbench

- Upstream feeder for the per-edge neighbour links.
- Accepts a valid/ready word stream of packed link parameters (weight, boundary condition) from the host/controller interface during STAGE_PARAMETERS_LOADING.
- Distributes the parameters into per-link registers whose flat outputs drive each link's weight_in/boundary_condition_in.
- Reports completion and malformed input to the stage controller.

---
 rtl/link_parameter_loader.sv | 170 +++++++++++++++++
 tb/tb_link_parameter_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_parameter_loader.sv
`default_nettype none
// ============================================================================
//  Module      : link_parameter_loader
//  Description : Loads packed per-link parameters (weight, boundary condition)
//                from a valid/ready word stream while the global stage is
//                PARAMETERS_LOADING. Each link gets its own register, and the
//                flat outputs drive the links directly. Completion and
//                malformed input are reported to the stage controller.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                    : clock
//    reset                  : synchronous, active-high reset
//    global_stage           : current global stage code
//    in_data                : packed entries; entry k at [k*ENTRY_WIDTH +: ENTRY_WIDTH],
//                             entry [1:0] = boundary condition, upper bits = weight
//    in_valid               : in_data valid
//    in_ready               : loader accepts a word this cycle
//    weight_out             : link i weight at [i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH]
//    boundary_condition_out : link i condition at [i*2 +: 2]
//    load_done              : full parameter set loaded
//    load_error             : sticky; clamped weight or aborted load
// ============================================================================
module link_parameter_loader #(
  parameter int NUM_LINKS   = 12,
  parameter int MAX_WEIGHT  = 2,
  parameter int IN_WIDTH    = 32,
  parameter int STAGE_WIDTH = 3,
  // Stage code of STAGE_PARAMETERS_LOADING in the shared stage definitions.
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1)
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [STAGE_WIDTH-1:0]                             global_stage,
  input  logic [IN_WIDTH-1:0]                                in_data,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  output logic [NUM_LINKS*$clog2(MAX_WEIGHT+1)-1:0]          weight_out,
  output logic [NUM_LINKS*2-1:0]                             boundary_condition_out,
  output logic                                               load_done,
  output logic                                               load_error
);

  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1);
  localparam int ENTRY_WIDTH    = LINK_BIT_WIDTH + 2;
  localparam int EPW            = IN_WIDTH / ENTRY_WIDTH;
  localparam int NUM_WORDS      = (NUM_LINKS + EPW - 1) / EPW;
  localparam int WIDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [LINK_BIT_WIDTH-1:0] MAX_W_CODE = LINK_BIT_WIDTH'(MAX_WEIGHT);
  localparam logic [WIDX_W-1:0]         LAST_WORD  = WIDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [WIDX_W-1:0]                   word_idx_q, word_idx_d;
  logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_q, weight_d;
  logic [NUM_LINKS*2-1:0]              bc_q, bc_d;
  logic                                load_done_q, load_done_d;
  logic                                load_error_q, load_error_d;
  logic                                in_ready_w;
  logic                                stage_is_load_w;
  logic [ENTRY_WIDTH-1:0]              entry_w;
  logic [LINK_BIT_WIDTH-1:0]           weight_w;

  assign stage_is_load_w = (global_stage == STAGE_PARAMETERS_LOADING);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    weight_d     = weight_q;
    bc_d         = bc_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    in_ready_w   = 1'b0;
    entry_w      = '0;
    weight_w     = '0;

    case (state_q)
      S_IDLE: begin
        // Parameter registers are deliberately kept; only status restarts.
        if (stage_is_load_w) begin
          state_d      = S_LOAD;
          word_idx_d   = '0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
        end
      end

      S_LOAD: begin
        // Ready depends on state only so the upstream never sees a
        // combinational path from in_valid back to in_ready.
        in_ready_w = 1'b1;
        if (!stage_is_load_w) begin
          // Abort: any handshake in this same cycle is dropped.
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end else if (in_valid) begin
          // Iterate over links (constant word/slot per link) rather than
          // over entries, so the write targets are static.
          for (int i = 0; i < NUM_LINKS; i++) begin
            if (word_idx_q == WIDX_W'(i / EPW)) begin
              entry_w  = in_data[(i % EPW)*ENTRY_WIDTH +: ENTRY_WIDTH];
              weight_w = entry_w[ENTRY_WIDTH-1:2];
              if (weight_w > MAX_W_CODE) begin
                weight_w     = MAX_W_CODE;
                load_error_d = 1'b1;
              end
              weight_d[i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = weight_w;
              bc_d[i*2 +: 2]                               = entry_w[1:0];
            end
          end
          if (word_idx_q == LAST_WORD) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
          end
        end
      end

      S_DONE: begin
        // load_done remains set through IDLE until the next load starts.
        if (!stage_is_load_w) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      weight_q     <= '0;
      bc_q         <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      weight_q     <= weight_d;
      bc_q         <= bc_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready               = in_ready_w;
  assign weight_out             = weight_q;
  assign boundary_condition_out = bc_q;
  assign load_done              = load_done_q;
  assign load_error             = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_link_parameter_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_parameter_loader
//  Description : Self-checking bench for link_parameter_loader using directed
//                steps with random word contents and a link-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_link_parameter_loader;

  localparam int NL  = 12;
  localparam int EPW = 8;
  localparam int NW  = 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PL   = 3'd1;
  localparam logic [2:0] ST_ML   = 3'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    global_stage;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NL*2-1:0] weight_out;
  logic [NL*2-1:0] boundary_condition_out;
  logic          load_done;
  logic          load_error;

  link_parameter_loader #(
    .NUM_LINKS               (NL),
    .MAX_WEIGHT              (2),
    .IN_WIDTH                (32),
    .STAGE_WIDTH             (3),
    .STAGE_PARAMETERS_LOADING(ST_PL)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .global_stage           (global_stage),
    .in_data                (in_data),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .weight_out             (weight_out),
    .boundary_condition_out (boundary_condition_out),
    .load_done              (load_done),
    .load_error             (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Link-level reference state
  int exp_w [NL];
  int exp_bc[NL];
  bit exp_done;
  bit exp_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      exp_w[i]  = 0;
      exp_bc[i] = 0;
    end
  endtask

  // Apply one accepted word to the link model: 4-bit entries, low 2 bits are
  // the boundary code, high 2 bits the weight, clamped to 2.
  task automatic model_word(input int widx, input logic [31:0] d);
    int link;
    int f;
    for (int k = 0; k < EPW; k++) begin
      link = widx*EPW + k;
      if (link < NL) begin
        f = int'((d >> (4*k)) & 32'hF);
        exp_bc[link] = f % 4;
        exp_w[link]  = f / 4;
        if (exp_w[link] > 2) begin
          exp_w[link] = 2;
          exp_err     = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag, input logic exp_ready);
    logic [NL*2-1:0] ew;
    logic [NL*2-1:0] eb;
    for (int i = 0; i < NL; i++) begin
      ew[i*2 +: 2] = 2'(exp_w[i]);
      eb[i*2 +: 2] = 2'(exp_bc[i]);
    end
    chk({tag, ":weight_out"}, 64'(weight_out), 64'(ew));
    chk({tag, ":bc_out"},     64'(boundary_condition_out), 64'(eb));
    chk({tag, ":in_ready"},   64'(in_ready), 64'(exp_ready));
    chk({tag, ":load_done"},  64'(load_done), 64'(exp_done));
    chk({tag, ":load_error"}, 64'(load_error), 64'(exp_err));
  endtask

  // Offer one word after 'gaps' idle cycles; the loader is in LOAD throughout.
  task automatic send_word(input int widx, input logic [31:0] d, input int gaps);
    in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      in_data = $urandom;
      step();
      check_all("gap", 1'b1);
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    model_word(widx, d);
    if (widx == NW-1) exp_done = 1'b1;
    check_all("word", (widx != NW-1));
  endtask

  task automatic enter_load();
    global_stage = ST_PL;
    step();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check_all("enter", 1'b1);
  endtask

  task automatic leave_stage();
    global_stage = ST_ML;
    step();
    check_all("leave", 1'b0);
  endtask

  initial begin
    logic [31:0] d;

    // ---------------- reset ----------------
    reset        = 1'b1;
    global_stage = ST_IDLE;
    in_valid     = 1'b0;
    in_data      = '0;
    model_clear();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    repeat (3) step();
    check_all("reset", 1'b0);
    reset = 1'b0;
    step();
    check_all("idle", 1'b0);

    // ---------------- back-to-back load ----------------
    enter_load();
    send_word(0, 32'h8765_4321, 0);
    send_word(1, 32'h0000_2211, 0);
    chk("link0_bc", 64'(boundary_condition_out[1:0]), 64'd1);
    chk("link10_bc", 64'(boundary_condition_out[21:20]), 64'd2);
    in_valid = 1'b1;
    in_data  = $urandom;
    step();
    step();
    in_valid = 1'b0;
    check_all("no_extra", 1'b0);

    // ---------------- toggled valid 1,0,0,1 ----------------
    leave_stage();
    enter_load();
    send_word(0, 32'h8765_4321, 0);
    send_word(1, 32'h0000_2211, 2);

    // ---------------- clamp of link 5 ----------------
    leave_stage();
    enter_load();
    d = $urandom;
    d[23:22] = 2'b11;
    send_word(0, d, 0);
    chk("clamp_link5_w", 64'(weight_out[11:10]), 64'd2);
    chk("clamp_err", 64'(load_error), 64'd1);
    send_word(1, $urandom, 1);
    leave_stage();
    enter_load();   // load_error cleared on LOAD entry

    // ---------------- random loads ----------------
    for (int r = 0; r < 6; r++) begin
      send_word(0, $urandom, $urandom_range(0, 2));
      send_word(1, $urandom, $urandom_range(0, 2));
      leave_stage();
      enter_load();
    end

    // ---------------- abort after one handshake ----------------
    send_word(0, $urandom, 0);
    global_stage = ST_ML;
    in_valid     = 1'b1;
    in_data      = $urandom;   // coincides with abort: discarded
    step();
    in_valid = 1'b0;
    exp_err  = 1'b1;
    check_all("abort", 1'b0);
    step();
    check_all("abort_hold", 1'b0);

    // ---------------- reset mid-LOAD ----------------
    enter_load();
    send_word(0, $urandom, 0);
    reset = 1'b1;
    step();
    model_clear();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check_all("rst_mid", 1'b0);
    reset = 1'b0;
    step();          // stage still PARAMETERS_LOADING: straight into LOAD
    check_all("rst_reload", 1'b1);
    send_word(0, $urandom, 0);
    send_word(1, $urandom, 0);

    // ---------------- measurement stage holds outputs ----------------
    leave_stage();
    for (int p = 0; p < 4; p++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      step();
      check_all("meas_hold", 1'b0);
    end
    in_valid = 1'b0;
    enter_load();
    send_word(0, $urandom, 1);
    send_word(1, $urandom, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
